// File: rtl/strip_timestamp.sv
// strip_timestamp: removes the trailing timestamp footer from an AXI4-Stream frame and presents it on a sideband.
// Define STRIP_TIMESTAMP_STATS_EN to add saturating frame_cnt/runt_cnt statistics outputs.
module strip_timestamp #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMESTAMP_WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [TIMESTAMP_WIDTH-1:0] m_ts_tdata,
  output logic                       m_ts_tvalid,
  input  logic                       m_ts_tready,
  output logic                       runt_err
`ifdef STRIP_TIMESTAMP_STATS_EN
  ,
  output logic [31:0]                frame_cnt,
  output logic [31:0]                runt_cnt
`endif
);
  localparam int FB = TIMESTAMP_WIDTH / DATA_WIDTH;
  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(FB + 1);
  typedef enum logic [1:0] {FILL, STREAM, TS_OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q [FB];
  logic [KW-1:0] keep_q [FB];
  logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d, footer;
  logic ts_valid_q, ts_valid_d, runt_q, runt_d, shift;
  // Footer as it will sit in the buffer after the final shift: entries 1..FB-1 plus the incoming beat.
  always_comb begin
    footer = '0;
    for (int i = 1; i < FB; i++) footer[(FB-i)*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
    footer[DATA_WIDTH-1:0] = s_axis_tdata;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ts_d = ts_q;
    ts_valid_d = ts_valid_q;
    runt_d = 1'b0;
    shift = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    m_axis_tdata = data_q[0];
    m_axis_tkeep = keep_q[0];
    case (state_q)
      FILL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          runt_d = 1'b1;
          cnt_d = '0;
        end else if (s_axis_tvalid) begin
          shift = 1'b1;
          cnt_d = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(FB - 1)) ? STREAM : FILL;
        end
      end
      STREAM: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          shift = 1'b1;
          if (s_axis_tlast) begin
            ts_d = footer;
            ts_valid_d = 1'b1;
            state_d = TS_OUT;
          end
        end
      end
      TS_OUT: begin
        if (m_ts_tready) begin
          ts_valid_d = 1'b0;
          cnt_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q <= '0;
      ts_q <= '0;
      ts_valid_q <= 1'b0;
      runt_q <= 1'b0;
      for (int i = 0; i < FB; i++) begin
        data_q[i] <= '0;
        keep_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ts_q <= ts_d;
      ts_valid_q <= ts_valid_d;
      runt_q <= runt_d;
      if (shift) begin
        for (int i = 0; i < FB - 1; i++) begin
          data_q[i] <= data_q[i+1];
          keep_q[i] <= keep_q[i+1];
        end
        data_q[FB-1] <= s_axis_tdata;
        keep_q[FB-1] <= s_axis_tkeep;
      end
    end
  end
  assign m_ts_tdata = ts_q;
  assign m_ts_tvalid = ts_valid_q;
  assign runt_err = runt_q;
`ifdef STRIP_TIMESTAMP_STATS_EN
  logic [31:0] frame_cnt_q, runt_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      runt_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 32'((state_q == TS_OUT) && m_ts_tready && !(&frame_cnt_q));
      runt_cnt_q <= runt_cnt_q + 32'(runt_q && !(&runt_cnt_q));
    end
  end
  assign frame_cnt = frame_cnt_q;
  assign runt_cnt = runt_cnt_q;
`endif
endmodule

// File: tb/tb_strip_timestamp.sv
// tb_strip_timestamp: randomized scoreboard bench for strip_timestamp with a byte-queue reference model.
module tb_strip_timestamp;
  localparam int DW = 8;
  localparam int TW = 72;
  localparam int FB = TW / DW;
  localparam int KW = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;
  logic [TW-1:0] m_ts_tdata;
  logic m_ts_tvalid;
  logic m_ts_tready;
  logic runt_err;
`ifdef STRIP_TIMESTAMP_STATS_EN
  logic [31:0] frame_cnt, runt_cnt;
`endif
  strip_timestamp #(.DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_ts_tdata(m_ts_tdata), .m_ts_tvalid(m_ts_tvalid), .m_ts_tready(m_ts_tready),
    .runt_err(runt_err)
`ifdef STRIP_TIMESTAMP_STATS_EN
    , .frame_cnt(frame_cnt), .runt_cnt(runt_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic last; logic [KW-1:0] keep; logic [DW-1:0] data;} beat_t;
  beat_t exp_q[$];
  logic [TW-1:0] exp_ts[$];
  logic [DW-1:0] fd[$];
  logic [KW-1:0] fk[$];
  beat_t e_beat;
  logic [TW-1:0] e_ts;
  int checks = 0, errors = 0;
  int exp_runts = 0, runt_seen = 0, stat_frames = 0, stat_runts = 0;
  bit rnd_ready = 1'b0, prev_runt = 1'b0;
  int ts_hold = 0, ts_wait = 0;
  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // Downstream data sink: always ready, or random backpressure.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  // Timestamp consumer: holds ready low for ts_hold cycles of each valid timestamp.
  initial begin
    m_ts_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!m_ts_tvalid) begin
        ts_wait = 0;
        m_ts_tready = (ts_hold == 0);
      end else begin
        ts_wait++;
        m_ts_tready = (ts_wait > ts_hold);
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_ts_tvalid", m_ts_tvalid, 0);
      chk("rst_ts_tdata", m_ts_tdata, 0);
      chk("rst_runt_err", runt_err, 0);
      prev_runt = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          e_beat = exp_q.pop_front();
          chk("m_axis_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e_beat);
        end
      end
      if (m_ts_tvalid) begin
        chk("ts_out_s_tready", s_axis_tready, 0);
        chk("ts_out_m_tvalid", m_axis_tvalid, 0);
        if (m_ts_tready) begin
          if (exp_ts.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ts: got %0h, expected no timestamp", m_ts_tdata);
          end else begin
            e_ts = exp_ts.pop_front();
            chk("m_ts_tdata", m_ts_tdata, e_ts);
          end
        end
      end
      if (runt_err) begin
        runt_seen++;
        chk("runt_pulse_width", prev_runt, 0);
      end
      prev_runt = runt_err;
    end
  end
  task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n = 0;
    bit hs;
    if ($urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        $display("FAIL drive_timeout: s_axis_tready stayed 0 for %0d cycles, expected 1", n);
        $fatal(1, "input handshake timeout");
      end
    end while (!hs);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask
  task automatic make(input int nd, input logic [TW-1:0] footer);
    fd.delete();
    fk.delete();
    for (int i = 0; i < nd; i++) begin
      fd.push_back(DW'($urandom));
      fk.push_back(KW'($urandom));
    end
    for (int i = FB - 1; i >= 0; i--) begin
      fd.push_back(footer[i*DW +: DW]);
      fk.push_back(KW'($urandom));
    end
  endtask
  // Reference: an n-beat frame yields its first n-FB beats and a timestamp of its last FB beats.
  task automatic send_frame(input int abort_at);
    int n = fd.size();
    int stop = (abort_at > 0) ? abort_at : n;
    logic [TW-1:0] ts = '0;
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at - FB; i++) exp_q.push_back({1'b0, fk[i], fd[i]});
    end else if (n <= FB) begin
      exp_runts++;
      stat_runts++;
    end else begin
      for (int i = 0; i < n - FB; i++) exp_q.push_back({i == n - FB - 1, fk[i], fd[i]});
      for (int i = n - FB; i < n; i++) ts = {ts[TW-DW-1:0], fd[i]};
      exp_ts.push_back(ts);
      stat_frames++;
    end
    for (int i = 0; i < stop; i++) drive(fd[i], fk[i], abort_at == 0 && i == n - 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_ts.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d beats and %0d timestamps pending, expected 0", exp_q.size(), exp_ts.size());
      exp_q.delete();
      exp_ts.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    rst = 1'b1;
    stat_frames = 0;
    stat_runts = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    make(60, 72'h00_0000_0000_0000_1F40);
    send_frame(0);
    wait_idle();
    rnd_ready = 1'b1;
    ts_hold = 20;
    send_frame(0);
    wait_idle();
    rnd_ready = 1'b0;
    ts_hold = 0;
    make(1, {DW'($urandom), 64'($urandom) << 32 | 64'($urandom)});
    send_frame(0);
    make(0, 72'h11_2233_4455_6677_8899);
    send_frame(0);
    make(64, 72'hAB_CDEF_0123_4567_89AB);
    send_frame(0);
    wait_idle();
    make(100, 72'h5A_A5A5_5A5A_A5A5_5AA5);
    send_frame(30);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      void'(fd.pop_front());
      void'(fk.pop_front());
    end
    send_frame(0);
    make(20, 72'h01_0203_0405_0607_0809);
    send_frame(0);
    wait_idle();
    rnd_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      ts_hold = $urandom_range(0, 5);
      make($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 30), {DW'($urandom), 64'($urandom) << 32 | 64'($urandom)});
      if (fd.size() == FB) repeat ($urandom_range(0, FB - 1)) void'(fd.pop_back());
      send_frame(0);
    end
    wait_idle();
    rnd_ready = 1'b0;
    ts_hold = 0;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      make((f == 1 || f == 3) ? 0 : $urandom_range(1, 30), {DW'($urandom), 64'($urandom)});
      if (f == 3) repeat (6) void'(fd.pop_back());
      send_frame(0);
    end
    wait_idle();
`ifdef STRIP_TIMESTAMP_STATS_EN
    chk("frame_cnt", frame_cnt, stat_frames);
    chk("runt_cnt", runt_cnt, stat_runts);
`endif
    chk("runt_count", runt_seen, exp_runts);
    chk("beats_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
